// File: rtl/lsu_dc1_arb.sv
// rtl/lsu_dc1_arb.sv - DC0 core/DMA arbiter with starvation guard, registers the DC1 address-check packet
module lsu_dc1_arb #(
  parameter int DMA_STARVE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        lsu_freeze,
  input  logic        core_valid_dc0,
  input  logic [31:0] core_addr_dc0,
  input  logic [1:0]  core_size_dc0,
  input  logic        core_store_dc0,
  output logic        core_stall_dc0,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [1:0]  dma_size,
  input  logic        dma_write,
  output logic        dma_ready,
  output logic        pkt_valid_dc1,
  output logic        pkt_dma_dc1,
  output logic        pkt_store_dc1,
  output logic        pkt_by_dc1,
  output logic        pkt_half_dc1,
  output logic        pkt_word_dc1,
  output logic [31:0] start_addr_dc1,
  output logic [31:0] end_addr_dc1,
  output logic        dma_forced
);

  typedef enum logic {NORM = 1'b0, FORCE = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(DMA_STARVE_LIMIT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        core_gnt, dma_gnt, adv;
  logic [31:0] win_addr, win_end;
  logic [1:0]  win_size;
  logic        win_store;
  logic [1:0]  win_off;

  // Combinational outputs are gated by reset so every port reads 0 while rst_l is low.
  assign adv = rst_l & ~lsu_freeze;

  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (adv) begin
      if (state == FORCE && dma_req) dma_gnt = 1'b1;
      else if (core_valid_dc0)       core_gnt = 1'b1;
      else if (dma_req)              dma_gnt = 1'b1;
    end
  end

  assign core_stall_dc0 = rst_l & core_valid_dc0 & ~core_gnt;
  assign dma_ready      = dma_gnt;
  assign dma_forced     = (state == FORCE);

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    if (!lsu_freeze) begin
      if (!dma_req || dma_gnt) cnt_nxt = 4'd0;
      else if (cnt < LIMIT)    cnt_nxt = cnt + 4'd1;
      case (state)
        NORM:    if (cnt_nxt == LIMIT)      state_nxt = FORCE;
        FORCE:   if (dma_gnt || !dma_req)   state_nxt = NORM;
        default: state_nxt = NORM;
      endcase
    end
  end

  always_comb begin
    win_addr  = dma_gnt ? dma_addr  : core_addr_dc0;
    win_size  = dma_gnt ? dma_size  : core_size_dc0;
    win_store = dma_gnt ? dma_write : core_store_dc0;
    case (win_size)
      2'd0:    win_off = 2'd0;
      2'd1:    win_off = 2'd1;
      default: win_off = 2'd3;
    endcase
    // Carry out of bit 31 is dropped on purpose; the region check catches wrapped ranges.
    win_end = win_addr + {30'd0, win_off};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= NORM;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pkt_valid_dc1  <= 1'b0;
      pkt_dma_dc1    <= 1'b0;
      pkt_store_dc1  <= 1'b0;
      pkt_by_dc1     <= 1'b0;
      pkt_half_dc1   <= 1'b0;
      pkt_word_dc1   <= 1'b0;
      start_addr_dc1 <= 32'd0;
      end_addr_dc1   <= 32'd0;
    end else if (!lsu_freeze) begin
      pkt_valid_dc1 <= core_gnt | dma_gnt;
      pkt_dma_dc1   <= dma_gnt;
      if (core_gnt || dma_gnt) begin
        pkt_store_dc1  <= win_store;
        pkt_by_dc1     <= (win_size == 2'd0);
        pkt_half_dc1   <= (win_size == 2'd1);
        pkt_word_dc1   <= win_size[1];
        start_addr_dc1 <= win_addr;
        end_addr_dc1   <= win_end;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dc1_arb.sv
// tb/tb_lsu_dc1_arb.sv - directed self-checking bench for lsu_dc1_arb
module tb_lsu_dc1_arb;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        lsu_freeze;
  logic        core_valid_dc0;
  logic [31:0] core_addr_dc0;
  logic [1:0]  core_size_dc0;
  logic        core_store_dc0;
  logic        core_stall_dc0;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [1:0]  dma_size;
  logic        dma_write;
  logic        dma_ready;
  logic        pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1;
  logic        pkt_by_dc1, pkt_half_dc1, pkt_word_dc1;
  logic [31:0] start_addr_dc1, end_addr_dc1;
  logic        dma_forced;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_dc1_arb #(.DMA_STARVE_LIMIT(15)) dut (
    .clk(clk), .rst_l(rst_l), .lsu_freeze(lsu_freeze),
    .core_valid_dc0(core_valid_dc0), .core_addr_dc0(core_addr_dc0),
    .core_size_dc0(core_size_dc0), .core_store_dc0(core_store_dc0),
    .core_stall_dc0(core_stall_dc0),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_size(dma_size),
    .dma_write(dma_write), .dma_ready(dma_ready),
    .pkt_valid_dc1(pkt_valid_dc1), .pkt_dma_dc1(pkt_dma_dc1),
    .pkt_store_dc1(pkt_store_dc1), .pkt_by_dc1(pkt_by_dc1),
    .pkt_half_dc1(pkt_half_dc1), .pkt_word_dc1(pkt_word_dc1),
    .start_addr_dc1(start_addr_dc1), .end_addr_dc1(end_addr_dc1),
    .dma_forced(dma_forced)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic v, input logic [31:0] a, input logic [1:0] s, input logic st);
    core_valid_dc0 = v; core_addr_dc0 = a; core_size_dc0 = s; core_store_dc0 = st;
  endtask

  task automatic set_dma(input logic v, input logic [31:0] a, input logic [1:0] s, input logic w);
    dma_req = v; dma_addr = a; dma_size = s; dma_write = w;
  endtask

  task automatic test_reset;
    rst_l = 1'b0;
    lsu_freeze = 1'b0;
    set_core(1'b1, 32'h100, 2'd0, 1'b0);
    set_dma(1'b1, 32'h200, 2'd2, 1'b1);
    #3;
    n_checks++; if (core_stall_dc0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", core_stall_dc0); end
    n_checks++; if (dma_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", dma_ready); end
    n_checks++; if ({pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_by_dc1, pkt_half_dc1, pkt_word_dc1, dma_forced} !== 7'd0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0", {pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_by_dc1, pkt_half_dc1, pkt_word_dc1, dma_forced}); end
    n_checks++; if (start_addr_dc1 !== 32'd0 || end_addr_dc1 !== 32'd0) begin
      n_fail++; $display("FAIL reset_addr got %h/%h exp 0/0", start_addr_dc1, end_addr_dc1); end
    set_core(1'b0, 32'h0, 2'd0, 1'b0);
    set_dma(1'b0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic test_dma_alone;
    tick;
    rst_l = 1'b1;
    set_dma(1'b1, 32'hF004_0000, 2'd2, 1'b1);
    #2;
    n_checks++; if (dma_ready !== 1'b1) begin n_fail++; $display("FAIL dma_alone_ready got %b exp 1", dma_ready); end
    n_checks++; if (core_stall_dc0 !== 1'b0) begin n_fail++; $display("FAIL dma_alone_stall got %b exp 0", core_stall_dc0); end
    tick;
    dma_req = 1'b0;
    #2;
    n_checks++; if ({pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_by_dc1, pkt_half_dc1, pkt_word_dc1} !== 6'b111001) begin
      n_fail++; $display("FAIL dma_alone_pkt got %b exp 111001", {pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_by_dc1, pkt_half_dc1, pkt_word_dc1}); end
    n_checks++; if (start_addr_dc1 !== 32'hF004_0000 || end_addr_dc1 !== 32'hF004_0003) begin
      n_fail++; $display("FAIL dma_alone_addr got %h/%h exp f0040000/f0040003", start_addr_dc1, end_addr_dc1); end
    n_checks++; if (dma_ready !== 1'b0) begin n_fail++; $display("FAIL dma_alone_ready_drop got %b exp 0", dma_ready); end
  endtask

  task automatic test_contention;
    tick;
    set_core(1'b1, 32'h100, 2'd0, 1'b0);
    set_dma(1'b1, 32'h2000, 2'd1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      #2;
      n_checks++; if (core_stall_dc0 !== 1'b0 || dma_ready !== 1'b0 || dma_forced !== 1'b0) begin
        n_fail++; $display("FAIL contention_core_cycle%0d got stall=%b ready=%b forced=%b exp 0/0/0", i, core_stall_dc0, dma_ready, dma_forced); end
      if (i == 2) begin
        n_checks++; if ({pkt_valid_dc1, pkt_dma_dc1, pkt_by_dc1} !== 3'b101 || start_addr_dc1 !== 32'h100 || end_addr_dc1 !== 32'h100) begin
          n_fail++; $display("FAIL contention_core_pkt got v/d/b=%b%b%b %h/%h exp 101 100/100", pkt_valid_dc1, pkt_dma_dc1, pkt_by_dc1, start_addr_dc1, end_addr_dc1); end
      end
      tick;
    end
    #2;
    n_checks++; if (dma_forced !== 1'b1 || dma_ready !== 1'b1 || core_stall_dc0 !== 1'b1) begin
      n_fail++; $display("FAIL contention_force got forced=%b ready=%b stall=%b exp 1/1/1", dma_forced, dma_ready, core_stall_dc0); end
    tick;
    set_core(1'b0, 32'h0, 2'd0, 1'b0);
    dma_req = 1'b0;
    #2;
    n_checks++; if (dma_forced !== 1'b0) begin n_fail++; $display("FAIL contention_back_norm got %b exp 0", dma_forced); end
    n_checks++; if ({pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_half_dc1} !== 4'b1101 || start_addr_dc1 !== 32'h2000 || end_addr_dc1 !== 32'h2001) begin
      n_fail++; $display("FAIL contention_dma_pkt got %b %h/%h exp 1101 2000/2001", {pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_half_dc1}, start_addr_dc1, end_addr_dc1); end
  endtask

  task automatic test_freeze;
    set_dma(1'b1, 32'h3000, 2'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      set_core(1'b1, 32'h300 + i, 2'd0, 1'b1);
    end
    for (int j = 0; j < 3; j++) begin
      tick;
      lsu_freeze = 1'b1;
      set_core((j != 1), 32'h400, 2'd2, 1'b0);
      #2;
      n_checks++; if (dma_ready !== 1'b0 || core_stall_dc0 !== core_valid_dc0) begin
        n_fail++; $display("FAIL freeze_comb%0d got ready=%b stall=%b exp 0/%b", j, dma_ready, core_stall_dc0, core_valid_dc0); end
      n_checks++; if (pkt_valid_dc1 !== 1'b1 || pkt_by_dc1 !== 1'b1 || start_addr_dc1 !== 32'h304 || end_addr_dc1 !== 32'h304) begin
        n_fail++; $display("FAIL freeze_hold%0d got v=%b %h/%h exp 1 304/304", j, pkt_valid_dc1, start_addr_dc1, end_addr_dc1); end
    end
    tick;
    lsu_freeze = 1'b0;
    set_core(1'b1, 32'h400, 2'd2, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      #2;
      n_checks++; if (core_stall_dc0 !== 1'b0 || dma_ready !== 1'b0) begin
        n_fail++; $display("FAIL freeze_resume%0d got stall=%b ready=%b exp 0/0", k, core_stall_dc0, dma_ready); end
      if (k == 1) begin
        n_checks++; if (start_addr_dc1 !== 32'h304) begin n_fail++; $display("FAIL freeze_last_hold got %h exp 304", start_addr_dc1); end
      end
      tick;
    end
    #2;
    n_checks++; if (dma_ready !== 1'b1 || core_stall_dc0 !== 1'b1 || dma_forced !== 1'b1) begin
      n_fail++; $display("FAIL freeze_force got ready=%b stall=%b forced=%b exp 1/1/1", dma_ready, core_stall_dc0, dma_forced); end
    tick;
    set_core(1'b0, 32'h0, 2'd0, 1'b0);
    dma_req = 1'b0;
  endtask

  task automatic test_wrap_size3;
    set_core(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b1);
    #2;
    n_checks++; if (core_stall_dc0 !== 1'b0) begin n_fail++; $display("FAIL wrap_stall got %b exp 0", core_stall_dc0); end
    tick;
    set_core(1'b0, 32'h0, 2'd0, 1'b0);
    set_dma(1'b1, 32'hFFFF_FFFE, 2'd2, 1'b0);
    #2;
    n_checks++; if ({pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_half_dc1} !== 4'b1011 || start_addr_dc1 !== 32'hFFFF_FFFF || end_addr_dc1 !== 32'h0) begin
      n_fail++; $display("FAIL wrap_half got %b %h/%h exp 1011 ffffffff/00000000", {pkt_valid_dc1, pkt_dma_dc1, pkt_store_dc1, pkt_half_dc1}, start_addr_dc1, end_addr_dc1); end
    tick;
    dma_req = 1'b0;
    set_core(1'b1, 32'h1000, 2'd3, 1'b0);
    #2;
    n_checks++; if ({pkt_dma_dc1, pkt_word_dc1} !== 2'b11 || end_addr_dc1 !== 32'h1) begin
      n_fail++; $display("FAIL wrap_word got dma/word=%b%b end=%h exp 11 00000001", pkt_dma_dc1, pkt_word_dc1, end_addr_dc1); end
    tick;
    set_core(1'b0, 32'h0, 2'd0, 1'b0);
    #2;
    n_checks++; if ({pkt_by_dc1, pkt_half_dc1, pkt_word_dc1} !== 3'b001 || start_addr_dc1 !== 32'h1000 || end_addr_dc1 !== 32'h1003) begin
      n_fail++; $display("FAIL size3 got %b %h/%h exp 001 1000/1003", {pkt_by_dc1, pkt_half_dc1, pkt_word_dc1}, start_addr_dc1, end_addr_dc1); end
    tick;
    #2;
    n_checks++; if (pkt_valid_dc1 !== 1'b0 || start_addr_dc1 !== 32'h1000) begin
      n_fail++; $display("FAIL idle_hold got v=%b start=%h exp 0 1000", pkt_valid_dc1, start_addr_dc1); end
  endtask

  task automatic test_reset_mid;
    tick;
    set_core(1'b1, 32'h500, 2'd0, 1'b0);
    set_dma(1'b1, 32'h600, 2'd0, 1'b0);
    for (int i = 0; i < 15; i++) tick;
    #2;
    n_checks++; if (dma_forced !== 1'b1 || pkt_valid_dc1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got forced=%b v=%b exp 1/1", dma_forced, pkt_valid_dc1); end
    rst_l = 1'b0;
    #1;
    n_checks++; if ({pkt_valid_dc1, dma_forced, dma_ready, core_stall_dc0, pkt_by_dc1} !== 5'd0 || start_addr_dc1 !== 32'd0 || end_addr_dc1 !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset got %b %h/%h exp 00000 0/0", {pkt_valid_dc1, dma_forced, dma_ready, core_stall_dc0, pkt_by_dc1}, start_addr_dc1, end_addr_dc1); end
    tick;
    rst_l = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      #2;
      n_checks++; if (dma_ready !== 1'b0 || core_stall_dc0 !== 1'b0) begin
        n_fail++; $display("FAIL mid_wait%0d got ready=%b stall=%b exp 0/0", i, dma_ready, core_stall_dc0); end
      @(posedge clk);
      #1;
    end
    #2;
    n_checks++; if (dma_ready !== 1'b1 || core_stall_dc0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_force got ready=%b stall=%b exp 1/1", dma_ready, core_stall_dc0); end
    tick;
    set_core(1'b0, 32'h0, 2'd0, 1'b0);
    dma_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_dma_alone;
    test_contention;
    test_freeze;
    tick;
    test_wrap_size3;
    test_reset_mid;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
